// File: rtl/serv_mem_arbiter.sv
// ============================================================================
// serv_mem_arbiter
//
// Shares one Wishbone-style 32-bit memory port between the SERV instruction
// bus (read-only) and data bus. Grants are registered and round-robin. A
// granted master owns the port until its ack, or until it drops cyc (abort).
// After a completed transfer the just-served master is blocked for one IDLE
// cycle (hold). This absorbs the core's one-cycle-late cyc deassertion, so
// the earliest re-grant is ack+2.
//
// Optional feature (define SERV_ARB_TIMEOUT_EN):
//   A TIMEOUT_W-bit watchdog counts grant cycles without an ack. When the
//   count reaches all-ones, the arbiter completes the transfer itself with a
//   zero-data ack and pulses o_err. A real ack in the same cycle wins.
//   Without the macro, o_err is tied to 0 and a grant waits forever.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_ibus_adr/cyc          instruction fetch request (held until ack)
//   o_ibus_rdt/ack          fetch read data / one-cycle ack
//   i_dbus_adr/dat/sel/we/cyc  data request (held until ack)
//   o_dbus_rdt/ack          data read data / one-cycle ack
//   o_wb_adr/dat/sel/we/cyc memory request (muxed from the granted master)
//   i_wb_rdt/ack            memory read data / ack
//   o_err                   watchdog timeout pulse (0 without the macro)
// ============================================================================
module serv_mem_arbiter #(
    parameter int AW        = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [AW-1:0] i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;   // last served master: 0 = ibus, 1 = dbus
    logic   hold_q, hold_d;   // block last master for one IDLE cycle
    logic   tmo;              // watchdog completes the transfer this cycle
    logic   done;             // transfer completes (real ack or timeout)
    logic   elig_i, elig_d;

`ifdef SERV_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    // A real ack in the same cycle takes priority over the watchdog.
    assign tmo = (state_q != IDLE) && !i_wb_ack && (&cnt_q);

    // Counter is held at zero in IDLE, so every grant starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!i_wb_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_w;
    assign unused_timeout_w = ^TIMEOUT_W;
    assign tmo              = 1'b0;
`endif

    assign done = i_wb_ack | tmo;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        hold_d  = hold_q;
        elig_i  = i_ibus_cyc && !(hold_q && !last_q);
        elig_d  = i_dbus_cyc && !(hold_q &&  last_q);
        case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                if (elig_i && elig_d) begin
                    // Both want the port: serve whoever was not served last.
                    state_d = last_q ? GNT_I : GNT_D;
                end else if (elig_i) begin
                    state_d = GNT_I;
                end else if (elig_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                // Completion beats a simultaneous cyc drop.
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    hold_d  = 1'b1;
                end else if (!i_ibus_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    hold_d  = 1'b0;
                end
            end
            GNT_D: begin
                if (done) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                    hold_d  = 1'b1;
                end else if (!i_dbus_cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                    hold_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Port mux and ack routing (all decoded from the registered state, so
    // there is no combinational path from a master's cyc to a new grant).
    // ------------------------------------------------------------------
    always_comb begin
        o_wb_adr   = '0;
        o_wb_dat   = '0;
        o_wb_sel   = '0;
        o_wb_we    = 1'b0;
        o_wb_cyc   = 1'b0;
        o_ibus_ack = 1'b0;
        o_dbus_ack = 1'b0;
        case (state_q)
            GNT_I: begin
                o_wb_adr   = i_ibus_adr;
                o_wb_sel   = 4'hf;
                o_wb_cyc   = i_ibus_cyc && !tmo;
                o_ibus_ack = done;
            end
            GNT_D: begin
                o_wb_adr   = i_dbus_adr;
                o_wb_dat   = i_dbus_dat;
                o_wb_sel   = i_dbus_sel;
                o_wb_we    = i_dbus_we;
                o_wb_cyc   = i_dbus_cyc && !tmo;
                o_dbus_ack = done;
            end
            default: ;
        endcase
    end

    // Read data is qualified only by the ack; a timeout ack returns zero.
    assign o_ibus_rdt = tmo ? 32'h0 : i_wb_rdt;
    assign o_dbus_rdt = tmo ? 32'h0 : i_wb_rdt;
    assign o_err      = tmo;

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Directed bench for serv_mem_arbiter. Stimulus runs on the falling edge and
// queues expectations; a monitor drains them shortly after and compares.
module tb_serv_mem_arbiter;

`ifdef SERV_ARB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we  = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_ack = 1'b0;
    logic        o_err;

    serv_mem_arbiter #(.AW(32), .TIMEOUT_W(TW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat),
        .i_dbus_sel(i_dbus_sel), .i_dbus_we(i_dbus_we),
        .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
        .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdt;
        bit          err;
    } ack_t;

    chk_t chk_q[$];
    ack_t exp_q[$];
    int   errs = 0;
    int   chks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic exp_ack(input bit is_d, input logic [31:0] rdt, input bit err);
        ack_t e;
        e.is_d = is_d;
        e.rdt  = rdt;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic nb();
        @(negedge i_clk);
    endtask

    // Monitor: drains queued value checks, and pops one expected ack each
    // time the DUT presents an ack on either bus.
    always @(negedge i_clk) begin
        chk_t c;
        ack_t e;
        #2;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            chks++;
            if (c.act !== c.exp) begin
                errs++;
                $display("FAIL %s: got %h want %h", c.name, c.act, c.exp);
            end
        end
        if (o_ibus_ack || o_dbus_ack) begin
            chks++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_ack: got iack=%b dack=%b want no ack", o_ibus_ack, o_dbus_ack);
            end else begin
                e = exp_q.pop_front();
                if (o_ibus_ack !== !e.is_d || o_dbus_ack !== e.is_d ||
                    (e.is_d ? o_dbus_rdt : o_ibus_rdt) !== e.rdt || o_err !== e.err) begin
                    errs++;
                    $display("FAIL ack_scoreboard: got iack=%b dack=%b irdt=%h drdt=%h err=%b want dbus=%b rdt=%h err=%b",
                             o_ibus_ack, o_dbus_ack, o_ibus_rdt, o_dbus_rdt, o_err, e.is_d, e.rdt, e.err);
                end
            end
        end
    end

    initial begin : stim
        int bad;
        // ---------------- reset state ----------------
        nb(); #1;
        chk("rst_wb_cyc", o_wb_cyc, 0);
        chk("rst_ibus_ack", o_ibus_ack, 0);
        chk("rst_dbus_ack", o_dbus_ack, 0);
        chk("rst_err", o_err, 0);
        chk("rst_wb_adr", o_wb_adr, 0);
        chk("rst_wb_dat", o_wb_dat, 0);
        chk("rst_wb_sel", o_wb_sel, 0);
        chk("rst_wb_we", o_wb_we, 0);
        nb(); i_rst = 1'b0;

        // ---------------- single ibus fetch ----------------
        nb(); i_ibus_cyc = 1'b1; i_ibus_adr = 32'h100; #1;
        chk("t1_no_comb_grant", o_wb_cyc, 0);
        nb(); #1;
        chk("t1_cyc_grant", o_wb_cyc, 1);
        chk("t1_adr", o_wb_adr, 32'h100);
        chk("t1_we", o_wb_we, 0);
        chk("t1_sel", o_wb_sel, 4'hf);
        chk("t1_dat", o_wb_dat, 0);
        nb(); #1;
        chk("t1_cyc_wait", o_wb_cyc, 1);
        nb(); i_wb_ack = 1'b1; i_wb_rdt = 32'hDEADBEEF; exp_ack(0, 32'hDEADBEEF, 0);
        nb(); i_wb_ack = 1'b0; #1;          // core drops cyc one cycle late
        chk("t1_idle_after_ack", o_wb_cyc, 0);
        nb(); i_ibus_cyc = 1'b0; #1;
        chk("t1_hold_no_regrant", o_wb_cyc, 0);

        // ---------------- simultaneous requests, alternation ----------------
        nb();
        i_ibus_cyc = 1'b1; i_ibus_adr = 32'h200;
        i_dbus_cyc = 1'b1; i_dbus_adr = 32'h2000; i_dbus_dat = 32'h12345678;
        i_dbus_sel = 4'b0011; i_dbus_we = 1'b1;
        nb(); #1;
        chk("t2_d_adr", o_wb_adr, 32'h2000);
        chk("t2_d_dat", o_wb_dat, 32'h12345678);
        chk("t2_d_sel", o_wb_sel, 4'b0011);
        chk("t2_d_we", o_wb_we, 1);
        chk("t2_d_cyc", o_wb_cyc, 1);
        i_wb_ack = 1'b1; i_wb_rdt = 32'hA5A5A5A5; exp_ack(1, 32'hA5A5A5A5, 0);
        nb(); i_wb_ack = 1'b0; #1;
        chk("t2_idle1", o_wb_cyc, 0);
        nb(); #1;
        chk("t2_i_adr", o_wb_adr, 32'h200);
        chk("t2_i_we", o_wb_we, 0);
        chk("t2_i_sel", o_wb_sel, 4'hf);
        chk("t2_i_dat", o_wb_dat, 0);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h11112222; exp_ack(0, 32'h11112222, 0);
        nb(); i_wb_ack = 1'b0; #1;
        chk("t2_idle2", o_wb_cyc, 0);
        nb(); #1;
        chk("t2_d2_we", o_wb_we, 1);
        chk("t2_d2_adr", o_wb_adr, 32'h2000);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h33334444; exp_ack(1, 32'h33334444, 0);
        nb(); i_wb_ack = 1'b0; #1;
        chk("t2_idle3", o_wb_cyc, 0);
        nb(); #1;
        chk("t2_i2_adr", o_wb_adr, 32'h200);
        chk("t2_i2_we", o_wb_we, 0);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h55556666; exp_ack(0, 32'h55556666, 0);
        nb(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0; #1;
        chk("t2_idle4", o_wb_cyc, 0);

        // ---------------- hold after dbus ack ----------------
        nb(); i_dbus_cyc = 1'b1; i_dbus_we = 1'b0; i_dbus_adr = 32'h3000; i_dbus_sel = 4'hf;
        nb(); #1;
        chk("t3_grant", o_wb_cyc, 1);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h77778888; exp_ack(1, 32'h77778888, 0);
        nb(); i_wb_ack = 1'b0; #1;
        chk("t3_ack1_idle", o_wb_cyc, 0);
        nb(); #1;
        chk("t3_hold_blocks", o_wb_cyc, 0);
        nb(); #1;
        chk("t3_regrant_ack2", o_wb_cyc, 1);
        chk("t3_regrant_adr", o_wb_adr, 32'h3000);

        // ---------------- reset mid GNT_D ----------------
        i_rst = 1'b1; i_wb_ack = 1'b1; #1;
        chk("t4_rst_cyc", o_wb_cyc, 0);
        chk("t4_rst_dack", o_dbus_ack, 0);
        chk("t4_rst_adr_idle", o_wb_adr, 0);
        nb(); i_rst = 1'b0; i_dbus_cyc = 1'b0; #1;
        chk("t4_post_rst_cyc", o_wb_cyc, 0);
        chk("t4_post_rst_iack", o_ibus_ack, 0);
        nb(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b1; i_ibus_adr = 32'h400;
        nb(); #1;
        chk("t4_ibus_grant", o_wb_cyc, 1);
        chk("t4_ibus_adr", o_wb_adr, 32'h400);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h9999AAAA; exp_ack(0, 32'h9999AAAA, 0);
        nb(); i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
        nb();

        // ---------------- watchdog / indefinite hold ----------------
        nb(); i_dbus_cyc = 1'b1; i_dbus_we = 1'b0; i_dbus_adr = 32'h4000; i_dbus_sel = 4'hf;
`ifdef SERV_ARB_TIMEOUT_EN
        for (int k = 0; k < 15; k++) begin
            nb(); #1;
            chk("t5_err_early", o_err, 0);
            chk("t5_ack_early", o_dbus_ack, 0);
        end
        nb(); exp_ack(1, 32'h0, 1); #1;
        chk("t5_tmo_cyc", o_wb_cyc, 0);
        nb(); i_dbus_cyc = 1'b0; #1;
        chk("t5_after_tmo_cyc", o_wb_cyc, 0);
`else
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            nb(); #1;
            if (o_err !== 1'b0 || o_wb_cyc !== 1'b1 || o_dbus_ack !== 1'b0) bad++;
        end
        chk("t5_hold100_glitches", bad, 0);
        nb(); i_wb_ack = 1'b1; i_wb_rdt = 32'hCAFEF00D; exp_ack(1, 32'hCAFEF00D, 0);
        nb(); i_wb_ack = 1'b0; i_dbus_cyc = 1'b0; #1;
        chk("t5_release_cyc", o_wb_cyc, 0);
`endif

        nb(); #1;
        chk("all_acks_seen", exp_q.size(), 0);
        nb();
        nb();
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/serv_mem_arbiter.md
Name: serv_mem_arbiter

Overview:
- Shares one Wishbone-style 32-bit memory port between the SERV instruction bus (read-only) and data bus.
- Sits between the core's ibus/dbus and the single memory/peripheral port.
- Grants are registered and round-robin; a granted master owns the port until its ack.
- A post-ack holdoff absorbs the core's one-cycle-late cyc deassertion.

Parameters:
- AW, 32, address width of all buses.
- TIMEOUT_W, 8, width of the watchdog counter. Used only with SERV_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_ibus_adr  in  AW  instruction fetch address
- i_ibus_cyc  in  1  instruction fetch request, held until ack
- o_ibus_rdt  out  32  fetch read data
- o_ibus_ack  out  1  fetch ack, one-cycle pulse
- i_dbus_adr  in  AW  data address
- i_dbus_dat  in  32  write data
- i_dbus_sel  in  4  byte enables
- i_dbus_we  in  1  write enable
- i_dbus_cyc  in  1  data request, held until ack
- o_dbus_rdt  out  32  data read data
- o_dbus_ack  out  1  data ack, one-cycle pulse
- o_wb_adr  out  AW  memory address
- o_wb_dat  out  32  memory write data
- o_wb_sel  out  4  memory byte enables
- o_wb_we  out  1  memory write enable
- o_wb_cyc  out  1  memory request
- i_wb_rdt  in  32  memory read data
- i_wb_ack  in  1  memory ack
- o_err  out  1  timeout pulse (0 without macro)

Behaviour:
- The FSM has three states: IDLE, GNT_I, GNT_D. Reset (async) forces IDLE, last=I, hold=0, timeout counter=0.
- Reset values of outputs:
  - o_wb_cyc=0, o_ibus_ack=0, o_dbus_ack=0, o_err=0.
  - o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0.
- Eligibility in IDLE: a master is eligible when its cyc=1, unless hold=1 and it is the last-served master.
- Arbitration in IDLE:
  - One eligible master: next state is its grant state.
  - Both eligible: grant the master that is not `last`.
  - None eligible: stay in IDLE. hold clears after any IDLE cycle.
- Grant latency: a request sampled in IDLE at cycle N drives o_wb_cyc=1 at N+1. There is no combinational cyc-to-cyc path.
- Mux in GNT_I:
  - o_wb_adr=i_ibus_adr, o_wb_we=0, o_wb_sel=4'hf, o_wb_dat=0.
  - o_wb_cyc=i_ibus_cyc.
- Mux in GNT_D: o_wb_* follow the dbus inputs; o_wb_cyc=i_dbus_cyc. In IDLE, o_wb_* are 0.
- Ack routing: o_x_ack = i_wb_ack & state==GNT_x, in the same cycle (combinational). i_wb_ack in IDLE is ignored.
- Read data: o_ibus_rdt and o_dbus_rdt forward i_wb_rdt unconditionally; they are valid only with their ack.
- Completion: on an ack, the next state is IDLE, last is set to the served master, and hold=1. The earliest re-grant is ack+2.
- Abort: if the granted master drops cyc before ack, the state returns to IDLE next cycle. last is updated and hold=0.
- Simultaneous ack and cyc drop in the same cycle is treated as a completion.
- Master contract: adr/dat/sel/we are stable while cyc=1. The arbiter does not latch them.
- Reset mid-transaction: o_wb_cyc drops immediately (async). No ack is emitted, and any pending memory ack is ignored thereafter.

Optional Feature:
- Macro SERV_ARB_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on every grant and increments each cycle in GNT_x while i_wb_ack=0.
  - When the count reaches all-ones, the arbiter emits o_x_ack=1 with o_x_rdt=0 and o_err=1 for one cycle. o_wb_cyc=0 that cycle.
  - The state then goes to IDLE with hold=1.
  - A real i_wb_ack in the same cycle wins: normal ack, o_err=0.
- Not defined: no counter is built, o_err is tied to 0, and a grant waits indefinitely for ack.

Test Plan:
- Reset, then ibus_cyc=1 adr=0x100, i_wb_ack at grant+2 with rdt=0xDEADBEEF -> o_wb_cyc high from cycle 1, o_ibus_ack pulse with rdt 0xDEADBEEF, o_dbus_ack stays 0.
- ibus and dbus raise cyc in the same cycle after reset (last=I) -> dbus granted first. After its ack plus a 1-cycle IDLE, ibus is granted. Order D,I, and the bench checks the alternation repeats.
- dbus write adr=0x2000 dat=0x12345678 sel=4'b0011 we=1 -> o_wb_* match exactly during GNT_D, o_wb_we=0 during any GNT_I.
- After the dbus ack, dbus_cyc is held high one extra cycle -> no re-grant in that cycle (hold). The grant occurs at ack+2 if cyc is still high.
- Assert i_rst mid-GNT_D -> o_wb_cyc=0 in the same cycle, state IDLE, no ack. After release, ibus_cyc=1 is granted normally.
- With SERV_ARB_TIMEOUT_EN, TIMEOUT_W=4, and no i_wb_ack -> o_dbus_ack=1, o_dbus_rdt=0, o_err=1 exactly 15 cycles after grant. Without the macro the bench checks o_err is constantly 0 and the grant is held for 100 cycles.
